aes_block_framer: RTL
=====================

Name: aes_block_framer

Overview:
- Upstream/downstream framing stage around the combinational AES-128 encryption core.
- Input side: collects four 32-bit plaintext words over a valid/ready stream into one 128-bit block.
- Core side: holds the block and a 128-bit key stable on the core inputs for a programmable settle window, then registers the core result.
- Output side: serializes the ciphertext as four 32-bit words over a valid/ready stream.

Parameters:
- SETTLE_CYCLES, 1, clock cycles the core inputs are held stable before core_out is sampled. Legal range 1..15; this is the multicycle allowance for the core.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- abort  in  1  synchronous abandon of the current block
- key_wr  in  1  load key_in into the key register
- key_in  in  128  cipher key
- in_valid  in  1  input word valid
- in_ready  out  1  framer accepts input word
- in_word  in  32  plaintext word; first word is block bits [127:96]
- core_in  out  128  block driven to the core's plaintext input
- core_key  out  128  key driven to the core's key input
- core_out  in  128  ciphertext returned by the core
- out_valid  out  1  ciphertext word valid
- out_ready  in  1  downstream accepts word
- out_word  out  32  ciphertext word; first word is result bits [127:96]
- busy  out  1  high in SETTLE and DRAIN

Behaviour:
- Reset values (async on rst=1):
  - state=COLLECT, word_idx=0, settle_cnt=0
  - block_reg=0, key_reg=0, result_reg=0
  - Outputs: in_ready=1, out_valid=0, out_word=0, core_in=0, core_key=0, busy=0
- Handshake: a transfer occurs on a rising edge where valid&ready=1.
  - in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready.
- COLLECT:
  - in_ready=1.
  - On each input transfer, in_word is written to block_reg[127-32*word_idx -: 32] and word_idx increments.
  - The transfer with word_idx=3 moves to SETTLE, loads settle_cnt=SETTLE_CYCLES-1 and wraps word_idx to 0.
- SETTLE:
  - in_ready=0, out_valid=0.
  - settle_cnt decrements each cycle.
  - On the edge where settle_cnt==0: result_reg<=core_out, move to DRAIN.
  - Latency: fourth input transfer at edge T gives the result capture at edge T+SETTLE_CYCLES, and out_valid=1 from that edge.
- DRAIN:
  - out_valid=1, out_word=result_reg[127-32*word_idx -: 32].
  - Each output transfer increments word_idx.
  - The fourth transfer returns to COLLECT with word_idx=0, so in_ready=1 in the following cycle.
  - out_word=0 whenever out_valid=0.
  - Stalls (out_ready=0) hold out_word and out_valid stable indefinitely.
- Core interface: core_in=block_reg and core_key=key_reg, both registered.
  - block_reg changes only in COLLECT, so core inputs are constant throughout SETTLE.
- key_wr:
  - Honoured in COLLECT and DRAIN: key_reg<=key_in at the next edge.
  - Ignored in SETTLE.
  - A key_wr in the same cycle as the fourth input transfer is honoured, and that block uses the new key.
- abort (synchronous, from any state):
  - Next state COLLECT, word_idx=0, settle_cnt=0.
  - Partial block_reg contents are discarded (not cleared).
  - Any undrained result is dropped; out_valid=0 at the next edge.
  - key_reg is preserved.
  - abort overrides a simultaneous input or output transfer; that word is not counted.
- Reset asserted mid-block or mid-drain returns all state and outputs to the reset values immediately, without waiting for clk.
- busy = (state!=COLLECT).

Optional Feature:
- Macro AES_FRAMER_BLKCNT_EN.
- Defined:
  - Adds output blk_count[31:0], reset 0.
  - Increments by 1 on the fourth output transfer of each block, wrapping 0xFFFFFFFF to 0.
  - Not cleared by abort.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - word_t (logic [31:0]) and block_t (logic [127:0])
  - framer_state_t enum {COLLECT, SETTLE, DRAIN}
  - WORDS_PER_BLOCK=4
  - FIPS-197 test vector constants for benches
- No sub-module; a single always_ff FSM plus datapath registers.
- The AES core is instantiated beside this block at the level above, not inside it.

Test Plan:
- Encryption with SETTLE_CYCLES=1, framer wired to the AES-128 core:
  - Stimulus: key_wr key 000102030405060708090a0b0c0d0e0f, then words 00112233, 44556677, 8899aabb, ccddeeff back-to-back.
  - Required: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; out_valid rises exactly 1 edge after the fourth input transfer.
- Backpressure:
  - Stimulus: same vector; out_ready toggled 1,0,0,1,0,1,1.
  - Required: no word lost or duplicated; out_word stable while stalled; in_ready=0 until the fourth output transfer.
- Latency, SETTLE_CYCLES=4:
  - Stimulus: same vector; key_wr with all-zero key asserted during SETTLE.
  - Required: key ignored; ciphertext still 69c4e0d8...; out_valid 4 edges after the fourth input transfer.
- Abort:
  - Stimulus: abort after 2 input words; then 4 fresh words of the vector.
  - Required: correct ciphertext. A second abort mid-DRAIN gives out_valid=0 next cycle and in_ready=1.
- Reset:
  - Stimulus: rst pulsed asynchronously mid-DRAIN.
  - Required: all outputs at reset values before the next clk edge; the next block (any key) encrypts correctly after key reload.
- With AES_FRAMER_BLKCNT_EN: 3 complete blocks plus 1 aborted block gives blk_count=3.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared word/block types, framer state encoding and FIPS-197
// reference constants for the AES-128 framing stage and its benches.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        COLLECT,
        SETTLE,
        DRAIN
    } framer_state_t;

    localparam int unsigned WORDS_PER_BLOCK = 4;

    // FIPS-197 Appendix C.1 AES-128 vector
    localparam block_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // LSB position of word idx inside a block; word 0 is the top word,
    // so (3 - idx) * 32 reduces to {~idx, 5'b0} for a 2-bit index.
    function automatic logic [6:0] word_lsb(input logic [1:0] idx);
        return {~idx, 5'd0};
    endfunction

endpackage

// File: rtl/aes_block_framer.sv
// aes_block_framer: gathers four 32-bit plaintext words into a block, holds
// block and key stable on the combinational AES core for SETTLE_CYCLES, then
// streams the captured ciphertext out as four 32-bit words.
// Optional feature macro: AES_FRAMER_BLKCNT_EN adds the blk_count output.
module aes_block_framer
    import aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         key_wr,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_word,
    output logic         busy
`ifdef AES_FRAMER_BLKCNT_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(WORDS_PER_BLOCK - 1);

    framer_state_t state;
    logic [1:0]    word_idx;
    logic [3:0]    settle_cnt;
    block_t        block_reg;
    block_t        key_reg;
    block_t        result_reg;

    // Core inputs come straight from registers, so they are glitch-free
    // and constant for the whole settle window.
    assign core_in  = block_reg;
    assign core_key = key_reg;

    // Framer FSM, datapath registers and registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            word_idx   <= '0;
            settle_cnt <= '0;
            block_reg  <= '0;
            key_reg    <= '0;
            result_reg <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_word   <= '0;
            busy       <= 1'b0;
`ifdef AES_FRAMER_BLKCNT_EN
            blk_count  <= '0;
`endif
        end else begin
            // Key loads are blocked only while the core is settling
            if (key_wr && state != SETTLE) begin
                key_reg <= key_in;
            end

            if (abort) begin
                state      <= COLLECT;
                word_idx   <= '0;
                settle_cnt <= '0;
                in_ready   <= 1'b1;
                out_valid  <= 1'b0;
                out_word   <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (in_valid) begin
                            block_reg[word_lsb(word_idx) +: 32] <= in_word;
                            if (word_idx == LAST_IDX) begin
                                state      <= SETTLE;
                                settle_cnt <= SETTLE_LOAD;
                                word_idx   <= '0;
                                in_ready   <= 1'b0;
                                busy       <= 1'b1;
                            end else begin
                                word_idx <= word_idx + 2'd1;
                            end
                        end
                    end

                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            result_reg <= core_out;
                            state      <= DRAIN;
                            out_valid  <= 1'b1;
                            out_word   <= core_out[127:96];
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end

                    DRAIN: begin
                        if (out_ready) begin
                            if (word_idx == LAST_IDX) begin
                                state     <= COLLECT;
                                word_idx  <= '0;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                                out_word  <= '0;
                                busy      <= 1'b0;
`ifdef AES_FRAMER_BLKCNT_EN
                                blk_count <= blk_count + 32'd1;
`endif
                            end else begin
                                // out_word is registered, so preload the next word
                                word_idx <= word_idx + 2'd1;
                                out_word <= result_reg[word_lsb(word_idx + 2'd1) +: 32];
                            end
                        end
                    end

                    default: begin
                        state     <= COLLECT;
                        word_idx  <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_word  <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
